// File: rtl/hd44780_blink_controller.sv
// Board bring-up UI: button latches an active-low DIP pattern as a blink mask, walked MSB first on the_led.
// Latency: accept lands 3 edges after the button rises; status LEDs are register outputs or simple reductions.
module hd44780_blink_controller #(
    parameter int NEWMASK_CLK_BITS     = 26,
    parameter int BLINKY_MASK_CLK_BITS = 19
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       button_internal,
    input  logic [7:0] dip_switch,
    output logic       the_led,
    output logic       o_led0,
    output logic       o_led1,
    output logic       o_led2,
    output logic       o_led3
);

    logic                            btn_s1;
    logic                            btn_s2;
    logic                            btn_p;
    logic                            press_event;
    logic                            accept;

    logic                            lock_flag;
    logic [NEWMASK_CLK_BITS-1:0]     lock_cnt;

    logic [7:0]                      mask;
    logic [2:0]                      step_idx;
    logic [BLINKY_MASK_CLK_BITS-1:0] prescaler;

    logic [NEWMASK_CLK_BITS-1:0]     hb_cnt;

    // The button is asynchronous to i_clk; only s2 onwards is safe to use.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_p  <= 1'b0;
        end else begin
            btn_s1 <= button_internal;
            btn_s2 <= btn_s1;
            btn_p  <= btn_s2;
        end
    end

    assign press_event = btn_s2 & ~btn_p;
    assign accept      = press_event & ~lock_flag;

    // The flag is still set in the cycle it clears, so a press landing there is rejected.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_flag <= 1'b0;
            lock_cnt  <= '0;
        end else if (accept) begin
            lock_flag <= 1'b1;
            lock_cnt  <= '0;
        end else if (lock_flag) begin
            lock_cnt <= lock_cnt + 1'b1;
            if (&lock_cnt) begin
                lock_flag <= 1'b0;
            end
        end
    end

    // Accept restarts the blink sequence at mask[7] and beats a coincident prescaler wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mask      <= 8'h00;
            step_idx  <= 3'd0;
            prescaler <= '0;
        end else if (accept) begin
            mask      <= ~dip_switch;
            step_idx  <= 3'd0;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler) begin
                step_idx <= step_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign the_led = mask[3'd7 - step_idx];
    assign o_led0  = lock_flag;
    assign o_led1  = btn_s2;
    assign o_led2  = |mask;
    assign o_led3  = hb_cnt[NEWMASK_CLK_BITS-1];

endmodule

// File: tb/tb_hd44780_blink_controller.sv
// Bench for hd44780_blink_controller: event-time model of accepts, lockout and blink position, plus literal anchors.
module tb_hd44780_blink_controller;

    localparam int NB   = 8;
    localparam int BB   = 3;
    localparam int LOCK = 1 << NB;
    localparam int STEP = 1 << BB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [7:0] dip = 8'hFF;
    logic       the_led, led0, led1, led2, led3;

    always #5 clk = ~clk;

    hd44780_blink_controller #(
        .NEWMASK_CLK_BITS    (NB),
        .BLINKY_MASK_CLK_BITS(BB)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .button_internal(btn),
        .dip_switch     (dip),
        .the_led        (the_led),
        .o_led0         (led0),
        .o_led1         (led1),
        .o_led2         (led2),
        .o_led3         (led3)
    );

    int errors = 0;
    int checks = 0;

    // Model state, expressed as edge timestamps rather than counters.
    int       e         = 0;
    int       last_rst  = 0;
    int       acc_edge  = -100000;
    int       origin    = 0;
    int       n_acc     = 0;
    bit       have_acc  = 1'b0;
    bit       started   = 1'b0;
    bit [7:0] m_mask    = 8'h00;
    bit       smp0 = 1'b0, smp1 = 1'b0, smp2 = 1'b0;  // button samples at edges e, e-1, e-2

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, got, exp);
        end
    endtask

    always @(posedge clk) begin
        bit press, locked;
        e++;
        if (rst) begin
            started  = 1'b1;
            last_rst = e;
            origin   = e;
            m_mask   = 8'h00;
            have_acc = 1'b0;
            smp0 = 1'b0; smp1 = 1'b0; smp2 = 1'b0;
        end else begin
            // A rise sampled at edge n is accepted at edge n+2.
            press  = smp1 & ~smp2;
            locked = have_acc && ((e - acc_edge) <= LOCK);
            if (press && !locked) begin
                m_mask   = ~dip;
                acc_edge = e;
                origin   = e;
                have_acc = 1'b1;
                n_acc++;
            end
            smp2 = smp1; smp1 = smp0; smp0 = btn;
        end
    end

    int rise_cnt  = 0;
    bit prev_led0 = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            check("the_led", the_led, m_mask[7 - (((e - origin) / STEP) % 8)]);
            check("o_led0", led0, have_acc && ((e - acc_edge) < LOCK));
            check("o_led1", led1, smp1);
            check("o_led2", led2, |m_mask);
            check("o_led3", led3, ((e - last_rst) % LOCK) >= (LOCK / 2));
        end
        if (led0 === 1'b1 && !prev_led0) rise_cnt++;
        prev_led0 = (led0 === 1'b1);
    end

    task automatic wait_until(input int target);
        while (e < target) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int expA, expB, expC, expR, t_raise, acc0;
        logic [7:0] pat_a, pat_b;
        pat_a = 8'b1010_0000;
        pat_b = 8'b1100_1100;

        // Reset for two edges.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_the_led", the_led, 1'b0);
        check("rst_leds", {led3, led2, led1, led0}, 4'b0000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 99) check("idle_the_led", the_led, 1'b0);
        end

        // First press: mask A0.
        dip  = 8'b0101_1111;
        btn  = 1'b1;
        expA = e + 3;
        wait_until(expA);
        check("acceptA_edge", acc_edge, expA);
        check("acceptA_led0", led0, 1'b1);
        check("acceptA_led2", led2, 1'b1);
        for (int c = 0; c < 64; c++) begin
            if (c % 8 == 0) check("blinkA", the_led, pat_a[7 - c / 8]);
            if (c == 47) btn = 1'b0;
            @(negedge clk);
        end

        // Press during lockout is dropped.
        wait_until(expA + 100);
        dip = 8'b0011_0011;
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        wait_until(expA + 128);
        check("lockedA_step0", the_led, 1'b1);
        wait_until(expA + 136);
        check("lockedA_step1", the_led, 1'b0);
        check("lockedA_led0", led0, 1'b1);

        // Lockout ends exactly 256 edges after accept.
        wait_until(expA + LOCK - 1);
        check("lock_last", led0, 1'b1);
        wait_until(expA + LOCK);
        check("lock_end", led0, 1'b0);

        // Press after lockout: mask CC.
        dip  = 8'b0011_0011;
        btn  = 1'b1;
        expB = e + 3;
        wait_until(expB);
        check("acceptB_edge", acc_edge, expB);
        for (int c = 0; c < 64; c++) begin
            if (c % 8 == 0) check("blinkB", the_led, pat_b[7 - c / 8]);
            if (c == 20) btn = 1'b0;
            @(negedge clk);
        end

        // Reset mid-lockout.
        wait_until(expB + 100);
        rst  = 1'b1;
        expR = e + 1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_edge", last_rst, expR);
        check("midrst_led0", led0, 1'b0);
        check("midrst_led2", led2, 1'b0);
        check("midrst_the_led", the_led, 1'b0);

        // Press 5 cycles later is accepted at once, then held for 1000 cycles.
        repeat (5) @(negedge clk);
        dip      = 8'h7E;
        rise_cnt = 0;
        acc0     = n_acc;
        btn      = 1'b1;
        t_raise  = e;
        expC     = e + 3;
        wait_until(expC);
        check("acceptC_edge", acc_edge, expC);
        check("acceptC_led0", led0, 1'b1);
        check("acceptC_the_led", the_led, 1'b1);
        wait_until(expR + 127);
        check("hb_127", led3, 1'b0);
        wait_until(expR + 128);
        check("hb_128", led3, 1'b1);
        wait_until(expR + 256);
        check("hb_256", led3, 1'b0);
        wait_until(expR + 384);
        check("hb_384", led3, 1'b1);
        wait_until(t_raise + 1000);
        check("held_rises", rise_cnt, 1);
        check("held_accepts", n_acc - acc0, 1);
        btn = 1'b0;

        // Random button, DIP and occasional reset activity.
        for (int i = 0; i < 300; i++) begin
            btn = 1'($urandom_range(0, 1));
            dip = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        rst = 1'b0;
        btn = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
